comp_sub_7_bits_seq: RTL and testbench

- Sequential inverse of the ASCII adder datapath: computes num_A - num_B modulo 2^W and reports a borrow flag.
- Uses a bit-serial subtractor, LSB first.
- Converts the difference to three BCD digits by shift-add-3 (double dabble) so the display path can show it directly.
- Sits between operand capture and the display driver; start/busy/done handshake.

---
 rtl/comp_sub_7_bits_seq.sv | 130 +++++++++++++
 tb/tb_comp_sub_7_bits_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/comp_sub_7_bits_seq.sv
// Bit-serial modulo-2^W subtractor with borrow flag and shift-add-3 binary-to-BCD
// conversion of the difference. Uses a start/busy/done handshake; results hold until
// the next operation completes.
module comp_sub_7_bits_seq #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] num_A,
    input  logic [W-1:0] num_B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] num_diff,
    output logic         borrow,
    output logic [3:0]   bcd_h,
    output logic [3:0]   bcd_t,
    output logic [3:0]   bcd_o
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        BCD  = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  diff_sr;
    logic          br;
    logic [CW-1:0] cnt;
    logic [3:0]    h_reg;
    logic [3:0]    t_reg;
    logic [3:0]    o_reg;

    logic          d_bit_c;
    logic          br_next_c;
    logic [2:0]    h_adj_c;
    logic [3:0]    t_adj_c;
    logic [3:0]    o_adj_c;

    // Full-subtractor bit and add-3 digit correction, both from current register values.
    // Only the low three bits of the adjusted hundreds digit survive the left shift.
    always_comb begin
        d_bit_c   = a_sr[0] ^ b_sr[0] ^ br;
        br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        h_adj_c   = 3'((h_reg >= 4'd5) ? h_reg + 4'd3 : h_reg);
        t_adj_c   = (t_reg >= 4'd5) ? t_reg + 4'd3 : t_reg;
        o_adj_c   = (o_reg >= 4'd5) ? o_reg + 4'd3 : o_reg;
    end

    // Control FSM with datapath registers and registered outputs.
    // During BCD the diff register rotates rather than shifts, so after W iterations it
    // holds the difference again and can be loaded into num_diff with no extra storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            h_reg    <= 4'd0;
            t_reg    <= 4'd0;
            o_reg    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            num_diff <= '0;
            borrow   <= 1'b0;
            bcd_h    <= 4'd0;
            bcd_t    <= 4'd0;
            bcd_o    <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= num_A;
                        b_sr  <= num_B;
                        br    <= 1'b0;
                        cnt   <= '0;
                        h_reg <= 4'd0;
                        t_reg <= 4'd0;
                        o_reg <= 4'd0;
                        busy  <= 1'b1;
                        state <= SUB;
                    end
                end
                SUB: begin
                    diff_sr <= {d_bit_c, diff_sr[W-1:1]};
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    br      <= br_next_c;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= BCD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BCD: begin
                    {h_reg, t_reg, o_reg, diff_sr} <=
                        {h_adj_c, t_adj_c, o_adj_c, diff_sr, diff_sr[W-1]};
                    if (cnt == CNT_LAST) begin
                        num_diff <= {diff_sr[W-2:0], diff_sr[W-1]};
                        borrow   <= br;
                        bcd_h    <= {h_adj_c, t_adj_c[3]};
                        bcd_t    <= {t_adj_c[2:0], o_adj_c[3]};
                        bcd_o    <= {o_adj_c[2:0], diff_sr[W-1]};
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_sub_7_bits_seq.sv
// Self-checking bench for comp_sub_7_bits_seq: directed operations with a result
// scoreboard, handshake timing, busy-time start/operand changes, held start and reset abort.
module tb_comp_sub_7_bits_seq;

    localparam int unsigned W = 7;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         brw;
        logic [3:0]   h;
        logic [3:0]   t;
        logic [3:0]   o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] num_A;
    logic [W-1:0] num_B;
    logic         busy;
    logic         done;
    logic [W-1:0] num_diff;
    logic         borrow;
    logic [3:0]   bcd_h;
    logic [3:0]   bcd_t;
    logic [3:0]   bcd_o;

    int   checks   = 0;
    int   failures = 0;
    res_t sb[$];
    res_t prev;

    comp_sub_7_bits_seq #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_A    (num_A),
        .num_B    (num_B),
        .busy     (busy),
        .done     (done),
        .num_diff (num_diff),
        .borrow   (borrow),
        .bcd_h    (bcd_h),
        .bcd_t    (bcd_t),
        .bcd_o    (bcd_o)
    );

    always #5 clk = ~clk;

    // Reference result: wrapped difference, unsigned borrow, decimal digits.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        int unsigned dv;
        r.diff = W'(a - b);
        r.brw  = (a < b);
        dv     = int'(r.diff);
        r.h    = 4'(dv / 100);
        r.t    = 4'((dv / 10) % 10);
        r.o    = 4'(dv % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input res_t e);
        chk({tag, "_diff"},   32'(num_diff), 32'(e.diff));
        chk({tag, "_borrow"}, 32'(borrow),   32'(e.brw));
        chk({tag, "_bcd_h"},  32'(bcd_h),    32'(e.h));
        chk({tag, "_bcd_t"},  32'(bcd_t),    32'(e.t));
        chk({tag, "_bcd_o"},  32'(bcd_o),    32'(e.o));
    endtask

    // One operation from an idle point between edges. hold keeps start high,
    // disturb_at toggles start/operands after that edge, abort_at resets after that edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                          input int disturb_at, input int abort_at);
        res_t e;
        start = 1'b1;
        num_A = a;
        num_B = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= 2 * int'(W); k++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk_outputs("hold", prev);
            @(posedge clk);
            #1;
            if (disturb_at > 0 && k == disturb_at) begin
                start = 1'b1;
                num_A = ~a;
                num_B = a;
            end
            if (disturb_at > 0 && k == disturb_at + 1) start = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk_outputs("abort", '0);
                if (sb.size() > 0) void'(sb.pop_back());
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_hold_done", 32'(done), 32'd0);
                    chk("abort_hold_busy", 32'(busy), 32'd0);
                end
                rst_n = 1'b1;
                prev  = '0;
                return;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end",   32'(busy), 32'd0);
        e = sb.pop_front();
        chk_outputs("result", e);
        prev = e;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_A = '0;
        num_B = '0;
        prev  = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_outputs("rst", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        run_op(7'h61, 7'h30, 1'b0, 0, 0);
        run_op(7'h30, 7'h31, 1'b0, 0, 0);
        run_op(7'h7F, 7'h00, 1'b0, 0, 0);
        run_op(7'h41, 7'h41, 1'b0, 0, 0);
        run_op(7'h15, 7'h20, 1'b0, 5, 0);

        // Held start: back-to-back operations with no idle gap.
        repeat (3) run_op(7'h35, 7'h05, 1'b1, 0, 0);
        start = 1'b0;
        @(negedge clk);
        chk("after_hold_done", 32'(done), 32'd0);
        chk("after_hold_busy", 32'(busy), 32'd0);

        run_op(7'h50, 7'h10, 1'b0, 0, 9);
        run_op(7'h64, 7'h0A, 1'b0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            run_op(W'($urandom), W'($urandom), 1'b0, 0, 0);
        end

        start = 1'b0;
        @(negedge clk);
        chk("final_done", 32'(done), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
